twos_to_signmag: RTL and testbench

TWOS_TO_SIGNMAG -- requirements
Module: twos_to_signmag

---
 rtl/twos_to_signmag.sv | 143 ++++++++++++++
 tb/tb_twos_to_signmag.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag.sv
`default_nettype none
// ============================================================================
// Module      : twos_to_signmag
// Description : Bit-serial two's-complement to sign/magnitude converter with
//               valid/ready handshakes on both sides; fixed WIDTH-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_to_signmag #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] magnitude,
    output logic             min_flag,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               carry_q,     carry_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic               sign_q,      sign_d;
    logic [WIDTH-1:0]   mag_q,       mag_d;
    logic               min_q,       min_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic               bit_in;
    logic               res_bit;

    // Negative words are inverted and incremented serially; the carry ripples
    // through the trailing zeros, so the most negative value lands on 2^(WIDTH-1).
    always_comb begin
        bit_in  = shreg_q[0];
        res_bit = sign_q ? (~bit_in ^ carry_q) : bit_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        shreg_d     = shreg_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        min_d       = min_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d    = word;
                    sign_d     = word[WIDTH-1];
                    min_d      = word[WIDTH-1] & (word[WIDTH-2:0] == '0);
                    mag_d      = '0;
                    cnt_d      = '0;
                    carry_d    = 1'b1;
                    state_d    = CONV;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CONV: begin
                mag_d   = {res_bit, mag_q[WIDTH-1:1]};
                shreg_d = shreg_q >> 1;
                if (sign_q) begin
                    carry_d = ~bit_in & carry_q;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            shreg_q     <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            min_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            shreg_q     <= shreg_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            min_q       <= min_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sign      = sign_q;
    assign magnitude = mag_q;
    assign min_flag  = min_q;

endmodule
`default_nettype wire

// File: tb/tb_twos_to_signmag.sv
`default_nettype none
// ============================================================================
// Module      : tb_twos_to_signmag
// Description : Directed and randomized self-checking bench for twos_to_signmag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_to_signmag;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] word = '0;
    logic         in_ready;
    logic         out_valid;
    logic         sign;
    logic [W-1:0] magnitude;
    logic         min_flag;
    logic         busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    twos_to_signmag #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word      (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .magnitude (magnitude),
        .min_flag  (min_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain signed arithmetic on the word value.
    function automatic int ref_value(input logic [W-1:0] w);
        int v;
        v = int'(w);
        if (v >= (1 << (W - 1))) v = v - (1 << W);
        return v;
    endfunction

    function automatic logic [31:0] ref_mag(input logic [W-1:0] w);
        int v;
        v = ref_value(w);
        return (v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] ref_sign(input logic [W-1:0] w);
        return (ref_value(w) < 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] ref_min(input logic [W-1:0] w);
        return (ref_value(w) == -(1 << (W - 1))) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered on the negedge right after the accept edge.
    task automatic wait_result(input logic [W-1:0] w, input bit rnd, input string tag);
        int  k;
        int  busy_cnt;
        bit  seen;
        bit  r;
        busy_cnt = 0;
        seen     = 1'b0;
        for (k = 0; k < W + 6; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            busy_cnt += int'(busy);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            word     = W'($urandom);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, seen ? 32'(k) : 32'd99, 32'(W));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(W));
        chk({tag, " sign"}, 32'(sign), ref_sign(w));
        chk({tag, " magnitude"}, 32'(magnitude), ref_mag(w));
        chk({tag, " min_flag"}, 32'(min_flag), ref_min(w));
        for (int s = 0; s < 40; s++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            @(negedge clk);
            if (r) break;
        end
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic send(input logic [W-1:0] w, input bit rnd, input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        word     = w;
        @(negedge clk);
        wait_result(w, rnd, tag);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " sign"}, 32'(sign), 32'd0);
        chk({tag, " magnitude"}, 32'(magnitude), 32'd0);
        chk({tag, " min_flag"}, 32'(min_flag), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  perm[512];
        int  j;
        int  tmp;
        int  k;
        bit  seen;

        repeat (2) @(negedge clk);
        chk_reset_values("reset");

        // First accept on the first edge after release.
        rst_n = 1'b1;
        send(9'h02D, 1'b0, "w02D");
        send(9'h12D, 1'b0, "w12D");
        send(9'h100, 1'b0, "w100");
        send(9'h1FF, 1'b0, "w1FF");
        send(9'h0FF, 1'b0, "w0FF");
        send(9'h000, 1'b0, "w000");

        // Backpressure with a second word waiting on in_valid.
        chk("bp in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        word      = 9'h0F0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen     = 1'b0;
        for (k = 0; k < W + 6; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bp latency", seen ? 32'(k) : 32'd99, 32'(W));
        in_valid = 1'b1;
        word     = 9'h1F0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
            chk("bp hold magnitude", 32'(magnitude), 32'd240);
            chk("bp hold sign", 32'(sign), 32'd0);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp handshake out_valid", 32'(out_valid), 32'd0);
        chk("bp handshake in_ready", 32'(in_ready), 32'd1);
        chk("bp handshake busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bp second captured busy", 32'(busy), 32'd1);
        chk("bp second captured in_ready", 32'(in_ready), 32'd0);
        wait_result(9'h1F0, 1'b0, "bp second");

        // Asynchronous reset in the middle of a conversion.
        chk("abort in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        word     = 9'h0AA;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before reset", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async reset");
        @(negedge clk);
        chk_reset_values("held reset");
        rst_n = 1'b1;
        send(9'h1F6, 1'b0, "after reset w1F6");

        // Every word once in random order with random stalls.
        for (int i = 0; i < 512; i++) perm[i] = i;
        for (int i = 511; i > 0; i--) begin
            j       = int'($urandom_range(0, i));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(W'(perm[i]), 1'b1, $sformatf("sweep %03h", perm[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
